// File: rtl/avr_pin_pkg.sv
// Shared pin-state codes for both directions of the AVR pin bridge, plus the
// level classifier used on the Verilog->AVR side.
package avr_pin_pkg;

  localparam int PIN_CODE_W = 3;

  localparam logic [PIN_CODE_W-1:0] PIN_LOW            = 3'd0;
  localparam logic [PIN_CODE_W-1:0] PIN_HIGH           = 3'd1;
  localparam logic [PIN_CODE_W-1:0] PIN_SHORTED        = 3'd2;
  localparam logic [PIN_CODE_W-1:0] PIN_PULLUP         = 3'd3;
  localparam logic [PIN_CODE_W-1:0] PIN_TRISTATE       = 3'd4;
  localparam logic [PIN_CODE_W-1:0] PIN_PULLDOWN       = 3'd5;
  localparam logic [PIN_CODE_W-1:0] PIN_ANALOG         = 3'd6;
  localparam logic [PIN_CODE_W-1:0] PIN_ANALOG_SHORTED = 3'd7;

  // Case equality so that x and z on the observed net are told apart from 0/1.
  function automatic logic [PIN_CODE_W-1:0] classify_pin(input logic net, input logic pull);
    if (net === 1'bz) return pull ? PIN_PULLUP : PIN_TRISTATE;
    else if (net === 1'bx) return PIN_SHORTED;
    else if (net === 1'b1) return PIN_HIGH;
    else return PIN_LOW;
  endfunction

endpackage

// File: rtl/avr_event_fifo.sv
// Show-ahead event queue. A push while full is dropped unless a pop happens at
// the same edge; dout reads as zero whenever the queue is empty.
module avr_event_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: empty gates dout until a slot is written.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/avr_pin_event_encoder.sv
// Verilog->AVR pin encoder: classify, glitch-filter and timestamp net changes.
// Optional AVR_PIN_ENC_PULLUP_EN adds pull_en so a floating net reads as pull-up.
module avr_pin_event_encoder
  import avr_pin_pkg::*;
#(
  parameter int FILTER_CYCLES = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int TS_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  conn,
`ifdef AVR_PIN_ENC_PULLUP_EN
  input  logic                  pull_en,
`endif
  output logic [PIN_CODE_W-1:0] cur_code,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [PIN_CODE_W-1:0] ev_code,
  output logic [TS_WIDTH-1:0]   ev_time,
  output logic                  overflow
);

  localparam int                CW   = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]     FC_V = CW'(FILTER_CYCLES);
  localparam int                EW   = PIN_CODE_W + TS_WIDTH;

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [TS_WIDTH-1:0]   cand_ts_q, cand_ts_d;
  logic [PIN_CODE_W-1:0] raw_q, raw_d;
  logic [PIN_CODE_W-1:0] cur_q, cur_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [PIN_CODE_W-1:0] cls;
  logic                  pull_bit;
  logic                  accept;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [EW-1:0]         fifo_dout;

`ifdef AVR_PIN_ENC_PULLUP_EN
  assign pull_bit = pull_en;
`else
  assign pull_bit = 1'b0;
`endif

  always_comb begin
    cls      = classify_pin(conn, pull_bit);
    fifo_pop = ev_ready && !fifo_empty;
    // cnt_q saturates at FILTER_CYCLES once raw_q has been held long enough.
    accept   = (cnt_q == FC_V) && (raw_q != cur_q);
    ts_d     = ts_q + 1'b1;
    cur_d    = accept ? raw_q : cur_q;
    ovf_d    = ovf_q | (accept && fifo_full && !fifo_pop);
    raw_d    = raw_q;
    cand_ts_d = cand_ts_q;
    cnt_d    = (cnt_q == FC_V) ? cnt_q : cnt_q + 1'b1;
    if (cls != raw_q) begin
      raw_d     = cls;
      cand_ts_d = ts_q;
      cnt_d     = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q      <= '0;
      cand_ts_q <= '0;
      raw_q     <= PIN_TRISTATE;
      cur_q     <= PIN_TRISTATE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      cand_ts_q <= cand_ts_d;
      raw_q     <= raw_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  avr_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (fifo_pop),
    .din   ({raw_q, cand_ts_q}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign cur_code = cur_q;
  assign ev_valid = !fifo_empty;
  assign ev_code  = fifo_dout[TS_WIDTH +: PIN_CODE_W];
  assign ev_time  = fifo_dout[TS_WIDTH-1:0];
  assign overflow = ovf_q;

endmodule
